// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: instruction fetch front end feeding RV32I decode.
// Holds the fetch PC, issues word reads over a valid/ready request channel,
// buffers in-order responses in a DEPTH-entry FIFO and presents {instr, pc}
// to decode. A redirect flushes the FIFO and drops responses still in flight.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready. imem_req_valid may drop without a
// transfer only when a redirect arrives (the request is abandoned on purpose).
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    // DEPTH must be a power of two >= 2 so the FIFO pointers wrap naturally.
    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [31:0]       RESET_ADDR = {RESET_PC[31:2], 2'b00};

    // RUN: fetching normally. DRAIN: waiting for stale responses after a redirect.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t            state;
    logic [31:0]       fetch_pc;
    logic [31:0]       rsp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_next;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       instr_mem [DEPTH];
    logic [31:0]       pc_mem    [DEPTH];

    logic              credit_ok;
    logic              accept;
    logic              pop;
    logic              push;
    logic [31:0]       redirect_addr;
    logic              redirect_pc_unused;

    // Low address bits of a redirect target are meaningless for word fetch.
    assign redirect_addr      = {redirect_pc[31:2], 2'b00};
    assign redirect_pc_unused = ^redirect_pc[1:0];

    // Words in flight plus words buffered may never exceed the FIFO size,
    // which is what keeps the FIFO from overflowing without backpressure on memory.
    assign credit_ok        = (outstanding + count) < DEPTH_CNT;
    assign imem_req_valid   = rst_n & (state == ST_RUN) & ~redirect_valid & credit_ok;
    assign imem_req_addr    = fetch_pc;
    assign accept           = imem_req_valid & imem_req_ready;
    assign instr_valid      = (count != '0);
    assign pop              = instr_valid & instr_ready;
    assign push             = imem_rsp_valid & (state == ST_RUN) & ~redirect_valid;
    assign outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

    // Head of the FIFO; forced to zero when empty so outputs are clean in reset.
    assign instr    = instr_valid ? instr_mem[rd_ptr] : 32'd0;
    assign instr_pc = instr_valid ? pc_mem[rd_ptr]    : 32'd0;

    // Fetch state: leave RUN on a redirect with stale words in flight, return once they are gone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (redirect_valid) begin
            state <= (outstanding_next != '0) ? ST_DRAIN : ST_RUN;
        end else if (state == ST_DRAIN && outstanding_next == '0) begin
            state <= ST_RUN;
        end
    end

    // Request PC and response PC; both jump to the redirect target together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_ADDR;
            rsp_pc   <= RESET_ADDR;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_addr;
            rsp_pc   <= redirect_addr;
        end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (push)   rsp_pc   <= rsp_pc + 32'd4;
        end
    end

    // Count of accepted requests whose response has not yet arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_next;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: data only, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]    <= rsp_pc;
        end
    end

    // A kept response into a full FIFO means the memory broke the in-order/credit contract.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count == DEPTH_CNT));

`ifdef FETCH_PERF_EN
    logic discard;
    assign discard = imem_rsp_valid & ~push;

    // Words handed to decode; unaffected by redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
        end else if (pop) begin
            perf_fetched <= perf_fetched + 32'd1;
        end
    end

    // Responses thrown away because a redirect made them stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_dropped <= 32'd0;
        end else if (discard) begin
            perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit: randomized bench for rv32i_fetch_unit with an
// epoch-tagged memory model and an expected-instruction queue.
module tb_rv32i_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  rv32i_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];          // {instr, pc} the decoder must see, in order
  logic [31:0] mq_addr[$];        // memory: accepted requests awaiting response
  logic [31:0] mq_data[$];
  int          mq_epoch[$];
  int          mq_cyc[$];
  int          epoch;
  int          cyc;
  logic [31:0] exp_req_addr;
  int          model_pops, model_dropped;

  int          dut_accepts, dut_pops;
  logic [31:0] pop_log[$];
  logic [31:0] prev_acc_addr;
  bit          prev_acc_valid;
  bit          watch_acc, watch_pop, wrap_seen, redir_pop_seen;

  int          ready_mode, iready_mode, rsp_mode;   // 0 low, 1 high, 2 random
  bit          rand_redirects;
  bit          do_redirect;
  logic [31:0] redirect_target;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic pick(input int mode);
    if (mode == 2) return logic'($urandom_range(0, 1));
    return logic'(mode == 1);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mq_addr.delete(); mq_data.delete(); mq_epoch.delete(); mq_cyc.delete();
    epoch = 0; cyc = 0;
    exp_req_addr = RESET_PC;
    model_pops = 0; model_dropped = 0;
    dut_accepts = 0; dut_pops = 0;
    pop_log.delete();
    prev_acc_valid = 0;
    do_redirect = 0;
  endtask

  // Assert reset between clock edges, check the asynchronous reset values, release on a negedge.
  task automatic apply_reset();
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver + compare: one clock cycle ----------------
  task automatic step();
    logic exp_rv, exp_iv, acc, pop, rsp, kept, redir;
    int   stale;
    if (rand_redirects && $urandom_range(0, 15) == 0) begin
      do_redirect = 1;
      redirect_target = $urandom;
    end
    redir = do_redirect;
    do_redirect = 0;
    imem_req_ready = pick(ready_mode);
    instr_ready    = pick(iready_mode);
    redirect_valid = redir;
    redirect_pc    = redir ? redirect_target : $urandom;
    rsp = 1'b0;
    if (mq_addr.size() != 0 && mq_cyc[0] < cyc)
      rsp = (rsp_mode == 1) || (rsp_mode == 2 && $urandom_range(0, 2) != 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mq_data[0] : $urandom;
    #1;

    // Requests are allowed only when nothing stale is in flight, no redirect, and room remains.
    stale = 0;
    foreach (mq_epoch[i]) if (mq_epoch[i] != epoch) stale++;
    exp_rv = !redir && stale == 0 && (mq_addr.size() + exp_q.size() < DEPTH);
    exp_iv = exp_q.size() != 0;
    check("req_valid", imem_req_valid, exp_rv);
    check("req_addr", imem_req_addr, exp_req_addr);
    check("instr_valid", instr_valid, exp_iv);
    if (exp_iv) begin
      check("instr", instr, exp_q[0][63:32]);
      check("instr_pc", instr_pc, exp_q[0][31:0]);
    end

    // Observations of the DUT's own handshakes for the directed checks.
    if (imem_req_valid && imem_req_ready) begin
      dut_accepts++;
      if (watch_acc) begin
        check("redir_first_req_addr", imem_req_addr, 32'h0000_2000);
        watch_acc = 0;
      end
      if (prev_acc_valid && prev_acc_addr == 32'hFFFF_FFFC) begin
        check("wrap_req_addr", imem_req_addr, 32'd0);
        wrap_seen = 1;
      end
      prev_acc_addr = imem_req_addr;
      prev_acc_valid = 1;
    end
    if (instr_valid && instr_ready) begin
      dut_pops++;
      pop_log.push_back(instr_pc);
      if (watch_pop) begin
        check("redir_first_instr_pc", instr_pc, 32'h0000_2000);
        watch_pop = 0;
      end
      if (redir) redir_pop_seen = 1;
    end
    if (redir) prev_acc_valid = 0;

    // Model update for the coming edge.
    acc  = exp_rv && imem_req_ready;
    pop  = exp_iv && instr_ready;
    kept = rsp && mq_epoch[0] == epoch && !redir;
    if (pop) begin
      void'(exp_q.pop_front());
      model_pops++;
    end
    if (rsp) begin
      if (kept) exp_q.push_back({mq_data[0], mq_addr[0]});
      else model_dropped++;
      void'(mq_addr.pop_front()); void'(mq_data.pop_front());
      void'(mq_epoch.pop_front()); void'(mq_cyc.pop_front());
    end
    if (acc) begin
      mq_addr.push_back(exp_req_addr);
      mq_data.push_back($urandom);
      mq_epoch.push_back(epoch);
      mq_cyc.push_back(cyc);
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      exp_req_addr = {redirect_target[31:2], 2'b00};
    end
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int drop_base;
    watch_acc = 0; watch_pop = 0; wrap_seen = 0; redir_pop_seen = 0;
    rand_redirects = 0;
    redirect_target = 32'd0;
    repeat (2) @(negedge clk);
    apply_reset();

    // Streaming: always-ready memory, 1-cycle latency, decoder always ready.
    ready_mode = 1; iready_mode = 1; rsp_mode = 1;
    repeat (20) step();
    check("stream_pop_count", dut_pops, 18);
    if (pop_log.size() >= 3) begin
      check("stream_pc0", pop_log[0], 32'h0000_0100);
      check("stream_pc1", pop_log[1], 32'h0000_0104);
      check("stream_pc2", pop_log[2], 32'h0000_0108);
    end else begin
      check("stream_pop_log_size", pop_log.size(), 3);
    end

    // Decoder stalled: fetch stops once DEPTH words are buffered.
    iready_mode = 0;
    repeat (12) step();
    check("stall_buffered", dut_accepts - dut_pops, DEPTH);
    check("stall_req_valid", imem_req_valid, 1'b0);
    check("stall_instr_valid", instr_valid, 1'b1);
    iready_mode = 1;
    repeat (10) step();

    // Random traffic with random redirects.
    ready_mode = 2; iready_mode = 2; rsp_mode = 2; rand_redirects = 1;
    repeat (1500) step();
    rand_redirects = 0;

    // Reset mid-stream, then three requests in flight and a redirect to a misaligned target.
    apply_reset();
    ready_mode = 1; iready_mode = 1; rsp_mode = 0;
    repeat (3) step();
    check("inflight_accepts", dut_accepts, 3);
    drop_base = model_dropped;
    do_redirect = 1; redirect_target = 32'h0000_2003;
    watch_acc = 1; watch_pop = 1;
    step();
    rsp_mode = 1;
    repeat (12) step();
    check("drain_dropped", model_dropped - drop_base, 3);
    check("drain_first_req_seen", watch_acc, 1'b0);
    check("drain_first_pop_seen", watch_pop, 1'b0);
`ifdef FETCH_PERF_EN
    check("perf_dropped_drain", perf_dropped, 32'd3);
`endif

    // Redirect coinciding with a response and a pop.
    redir_pop_seen = 0;
    do_redirect = 1; redirect_target = 32'h0000_3000;
    step();
    check("redir_pop_completed", redir_pop_seen, 1'b1);
    check("redir_fifo_empty", instr_valid, 1'b0);

    // PC wrap at the top of the address space.
    wrap_seen = 0;
    do_redirect = 1; redirect_target = 32'hFFFF_FFF4;
    step();
    repeat (10) step();
    check("wrap_seen", wrap_seen, 1'b1);

    // More random traffic.
    ready_mode = 2; iready_mode = 2; rsp_mode = 2; rand_redirects = 1;
    repeat (1500) step();
    rand_redirects = 0;
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, model_pops);
    check("perf_dropped", perf_dropped, model_dropped);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
